// File: rtl/param_cntr_pkg.sv
// Shared types and constants for the param_cntr loop counter.
package param_cntr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    localparam bit DIR_INC = 1'b0;
    localparam bit DIR_DEC = 1'b1;

endpackage

// File: rtl/param_cntr_if.sv
// Command/status bundle between the controlling unit (master) and the counter (slave).
interface param_cntr_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] step;
    logic             ld;
    logic             inc;
    logic             dec;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             zero;
    logic             tc;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output din, step, ld, inc, dec, start,
        input  dout, zero, tc, ovf, busy, done
    );

    modport slave (
        input  din, step, ld, inc, dec, start,
        output dout, zero, tc, ovf, busy, done
    );
endinterface

// File: rtl/param_cntr_alu.sv
// Combinational step adder/subtractor with carry/borrow detect and wrap or clamp.
module param_cntr_alu
    import param_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter bit          SAT   = MODE_WRAP
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             hits_zero
);

    logic [WIDTH:0] ext;

    // One extra bit holds the carry-out on increment or the borrow on decrement.
    always_comb begin
        ext = '0;
        if (dir == DIR_DEC) begin
            ext = {1'b0, a} - {1'b0, step};
        end else begin
            ext = {1'b0, a} + {1'b0, step};
        end
        ovf = ext[WIDTH];
        if (ovf && (SAT == MODE_SAT)) begin
            result = (dir == DIR_DEC) ? '0 : '1;
        end else begin
            result = ext[WIDTH-1:0];
        end
        hits_zero = (a != '0) && (result == '0);
    end

endmodule

// File: rtl/param_cntr.sv
// Up/down loop counter with load, stepped wrap/saturate counting and a self-timed run-to-zero mode.
module param_cntr
    import param_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter bit          SAT   = MODE_WRAP
) (
    input  logic        clk,
    input  logic        rst_n,
    param_cntr_if.slave bus
);

    state_e           state;
    logic [WIDTH-1:0] dout_q;
    logic             tc_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             alu_hits_zero;
    logic             alu_dir;

    assign alu_dir = bus.dec ? DIR_DEC : DIR_INC;

    param_cntr_alu #(
        .WIDTH (WIDTH),
        .SAT   (SAT)
    ) u_alu (
        .a         (dout_q),
        .step      (bus.step),
        .dir       (alu_dir),
        .result    (alu_result),
        .ovf       (alu_ovf),
        .hits_zero (alu_hits_zero)
    );

    // Priority: reset > start > ld > run-mode decrement > inc/dec.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            dout_q <= '0;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.start) begin
            state  <= ST_RUN;
            dout_q <= bus.din;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (bus.ld) begin
            state  <= ST_IDLE;
            dout_q <= bus.din;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (state == ST_RUN) begin
            // The zero check guards the decrement, so a run never borrows.
            if (dout_q == '0) begin
                state  <= ST_DONE;
                tc_q   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                dout_q <= dout_q - WIDTH'(1);
                tc_q   <= (dout_q == WIDTH'(1));
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.inc ^ bus.dec) begin
                dout_q <= alu_result;
                tc_q   <= alu_hits_zero;
                if (alu_ovf) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                tc_q <= 1'b0;
            end
        end
    end

    assign bus.dout = dout_q;
    assign bus.zero = (dout_q == '0);
    assign bus.tc   = tc_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_param_cntr.sv
// Drives a wrapping and a saturating counter with identical commands and checks both.
module tb_param_cntr;

    localparam int unsigned W   = 16;
    localparam int          MAX = 65535;

    logic clk;
    logic rst_n;

    param_cntr_if #(.WIDTH(W)) bus0 ();
    param_cntr_if #(.WIDTH(W)) bus1 ();

    param_cntr #(.WIDTH(W), .SAT(1'b0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    param_cntr #(.WIDTH(W), .SAT(1'b1)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: index 0 wraps, index 1 clamps; phase 0 idle, 1 counting down, 2 finished.
    int m_d     [2];
    bit m_tc    [2];
    bit m_ovf   [2];
    int m_phase;

    typedef struct {
        int       din;
        bit [3:0] op;    // {start, ld, inc, dec}
        int       step;
        int       d0;
        int       d1;
        bit [5:0] fl;    // {tc0, ovf0, tc1, ovf1, busy, done}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int din, bit [3:0] op, int step, int d0, int d1, bit [5:0] fl);
        vec_t v;
        v.din  = din;
        v.op   = op;
        v.step = step;
        v.d0   = d0;
        v.d1   = d1;
        v.fl   = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input int din, input bit ld, input bit inc,
                              input bit dec, input int step, input bit start);
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                m_d[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            m_phase = 0;
        end else if (start || ld) begin
            for (int i = 0; i < 2; i++) begin
                m_d[i] = din; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            m_phase = start ? 1 : 0;
        end else if (m_phase == 1) begin
            if (m_d[0] == 0) begin
                m_phase = 2;
                for (int i = 0; i < 2; i++) m_tc[i] = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    m_d[i]  = m_d[i] - 1;
                    m_tc[i] = (m_d[i] == 0);
                end
            end
        end else begin
            m_phase = 0;
            for (int i = 0; i < 2; i++) begin
                int r_val;
                m_tc[i] = 1'b0;
                if (inc != dec) begin
                    r_val = inc ? m_d[i] + step : m_d[i] - step;
                    if (r_val > MAX || r_val < 0) begin
                        m_ovf[i] = 1'b1;
                        if (i == 1) r_val = inc ? MAX : 0;
                        else        r_val = r_val & MAX;
                    end
                    m_tc[i] = (m_d[i] != 0) && (r_val == 0);
                    m_d[i]  = r_val;
                end
            end
        end
    endtask

    task automatic chk_model();
        chk("wrap_dout", int'(bus0.dout), m_d[0]);
        chk("wrap_zero", int'(bus0.zero), int'(m_d[0] == 0));
        chk("wrap_tc",   int'(bus0.tc),   int'(m_tc[0]));
        chk("wrap_ovf",  int'(bus0.ovf),  int'(m_ovf[0]));
        chk("wrap_busy", int'(bus0.busy), int'(m_phase == 1));
        chk("wrap_done", int'(bus0.done), int'(m_phase == 2));
        chk("sat_dout",  int'(bus1.dout), m_d[1]);
        chk("sat_zero",  int'(bus1.zero), int'(m_d[1] == 0));
        chk("sat_tc",    int'(bus1.tc),   int'(m_tc[1]));
        chk("sat_ovf",   int'(bus1.ovf),  int'(m_ovf[1]));
        chk("sat_busy",  int'(bus1.busy), int'(m_phase == 1));
        chk("sat_done",  int'(bus1.done), int'(m_phase == 2));
    endtask

    task automatic apply(input bit r, input int din, input bit ld, input bit inc,
                         input bit dec, input int step, input bit start);
        rst_n      = r;
        bus0.din   = W'(din);  bus1.din   = W'(din);
        bus0.ld    = ld;       bus1.ld    = ld;
        bus0.inc   = inc;      bus1.inc   = inc;
        bus0.dec   = dec;      bus1.dec   = dec;
        bus0.step  = W'(step); bus1.step  = W'(step);
        bus0.start = start;    bus1.start = start;
        @(posedge clk);
        model_edge(r, din, ld, inc, dec, step, start);
        #1;
        chk_model();
    endtask

    initial begin
        m_d[0] = 0; m_d[1] = 0; m_tc[0] = 0; m_tc[1] = 0;
        m_ovf[0] = 0; m_ovf[1] = 0; m_phase = 0;

        tbl.push_back(mk(16'hFFFE, 4'b0100,  0, 16'hFFFE, 16'hFFFE, 6'b000000));
        tbl.push_back(mk(0,        4'b0010,  3, 16'h0001, 16'hFFFF, 6'b010100));
        tbl.push_back(mk(0,        4'b0001,  1, 16'h0000, 16'hFFFE, 6'b110100));
        tbl.push_back(mk(5,        4'b0100,  0, 5,        5,        6'b000000));
        tbl.push_back(mk(0,        4'b0001,  8, 16'hFFFD, 0,        6'b011100));
        tbl.push_back(mk(16'hFFF0, 4'b0100,  0, 16'hFFF0, 16'hFFF0, 6'b000000));
        tbl.push_back(mk(0,        4'b0010, 32, 16'h0010, 16'hFFFF, 6'b010100));
        tbl.push_back(mk(0,        4'b0011,  5, 16'h0010, 16'hFFFF, 6'b010100));
        tbl.push_back(mk(0,        4'b0010,  0, 16'h0010, 16'hFFFF, 6'b010100));
        tbl.push_back(mk(0,        4'b0001,  0, 16'h0010, 16'hFFFF, 6'b010100));
        tbl.push_back(mk(0,        4'b0100,  0, 0,        0,        6'b000000));
        tbl.push_back(mk(0,        4'b0001,  0, 0,        0,        6'b000000));
        tbl.push_back(mk(3,        4'b1100,  0, 3,        3,        6'b000010));
        tbl.push_back(mk(0,        4'b0010,  1, 2,        2,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 1,        1,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b101010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b000001));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b000000));
        tbl.push_back(mk(0,        4'b1000,  0, 0,        0,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b000001));
        tbl.push_back(mk(9,        4'b1000,  0, 9,        9,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 8,        8,        6'b000010));
        tbl.push_back(mk(7,        4'b0100,  0, 7,        7,        6'b000000));
        tbl.push_back(mk(0,        4'b0000,  0, 7,        7,        6'b000000));
        tbl.push_back(mk(1,        4'b1000,  0, 1,        1,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b101010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b000001));
        tbl.push_back(mk(2,        4'b1000,  0, 2,        2,        6'b000010));
        tbl.push_back(mk(0,        4'b0000,  0, 1,        1,        6'b000010));
        tbl.push_back(mk(0,        4'b0001,  4, 0,        0,        6'b101010));
        tbl.push_back(mk(0,        4'b0000,  0, 0,        0,        6'b000001));
        tbl.push_back(mk(0,        4'b0001,  1, 16'hFFFF, 0,        6'b010100));
        tbl.push_back(mk(0,        4'b0000,  0, 16'hFFFF, 0,        6'b010100));

        apply(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        apply(1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1, 1'b1);
        chk("rst_dout", int'(bus0.dout), 0);
        chk("rst_zero", int'(bus0.zero), 1);
        chk("rst_flags", int'({bus0.tc, bus0.ovf, bus0.busy, bus0.done}), 0);

        foreach (tbl[k]) begin
            apply(1'b1, tbl[k].din, tbl[k].op[2], tbl[k].op[1], tbl[k].op[0],
                  tbl[k].step, tbl[k].op[3]);
            chk($sformatf("vec%0d_d0", k), int'(bus0.dout), tbl[k].d0);
            chk($sformatf("vec%0d_d1", k), int'(bus1.dout), tbl[k].d1);
            chk($sformatf("vec%0d_z0", k), int'(bus0.zero), int'(tbl[k].d0 == 0));
            chk($sformatf("vec%0d_fl", k),
                int'({bus0.tc, bus0.ovf, bus1.tc, bus1.ovf, bus0.busy, bus0.done}),
                int'(tbl[k].fl));
        end

        // Reset in the middle of a run clears everything on the next edge.
        apply(1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) apply(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("midrun_busy", int'(bus0.busy), 1);
        apply(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("midrun_rst_dout", int'(bus0.dout), 0);
        chk("midrun_rst_flags",
            int'({bus0.tc, bus0.ovf, bus0.busy, bus0.done, bus0.zero}), 1);

        for (int i = 0; i < 3000; i++) begin
            bit r, ld, inc, dec, st;
            int din, step;
            r    = ($urandom_range(0, 99) != 0);
            st   = ($urandom_range(0, 19) == 0);
            ld   = ($urandom_range(0, 9) == 0);
            inc  = ($urandom_range(0, 9) < 4);
            dec  = ($urandom_range(0, 9) < 4);
            din  = st ? int'($urandom_range(0, 6)) : int'($urandom_range(0, MAX));
            case ($urandom_range(0, 3))
                0:       step = 0;
                1:       step = int'($urandom_range(1, 4));
                2:       step = int'($urandom_range(0, MAX));
                default: step = int'($urandom_range(MAX - 8, MAX));
            endcase
            apply(r, din, ld, inc, dec, step, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
